gpio_params_loader: RTL and testbench



---
 rtl/gpio_params_loader_if.sv | 13 +
 rtl/gpio_params_loader.sv | 97 +++++++++
 tb/tb_gpio_params_loader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/gpio_params_loader_if.sv
// gpio_params_loader_if: PS-facing GPIO channels and the packed active-bank bus.
interface gpio_params_loader_if #(
    parameter int GPIO_WIDTH  = 32,
    parameter int PARAM_COUNT = 16,
    parameter int PARAM_SETS  = 16
);
    logic [GPIO_WIDTH-1:0]                        gp_in;
    logic [15:0]                                  gp_ctrl;
    logic [GPIO_WIDTH-1:0]                        gp_status;
    logic [PARAM_SETS*PARAM_COUNT*GPIO_WIDTH-1:0] params_data;
    modport master (output gp_in, gp_ctrl, input gp_status, params_data);
    modport slave (input gp_in, gp_ctrl, output gp_status, params_data);
endinterface

// File: rtl/gpio_params_loader.sv
// gpio_params_loader: loads parameter words into a shadow bank and commits whole sets to the active bank.
module gpio_params_loader #(
    parameter int GPIO_WIDTH  = 32,
    parameter int PARAM_COUNT = 16,
    parameter int PARAM_SETS  = 16
) (
    input  logic                  i_clk,
    input  logic                  i_resetn,
    gpio_params_loader_if.slave   io_gpio
);
    localparam int NW = PARAM_SETS * PARAM_COUNT;
    localparam int CW = PARAM_COUNT > 1 ? $clog2(PARAM_COUNT) : 1;
    localparam int AW = NW > 1 ? $clog2(NW) : 1;

    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_COPY, S_DONE} state_t;

    state_t                       r_state, w_next;
    logic [GPIO_WIDTH-1:0]        r_in_s1, r_in_s2, r_data;
    logic [14:0]                  r_ctrl_s1, r_ctrl_s2;
    logic                         r_tog_seen, r_ack, r_err, r_clr, r_commit;
    logic [3:0]                   r_set;
    logic [7:0]                   r_param;
    logic [CW-1:0]                r_cnt;
    logic [GPIO_WIDTH-1:0]        r_shadow [NW];
    logic [NW*GPIO_WIDTH-1:0]     r_active;
    logic                         w_pending, w_valid;
    logic [AW-1:0]                w_wr_idx, w_cp_idx;

    // control bit 12 is reserved, so only the 15 meaningful bits are synchronized
    assign w_pending = r_ctrl_s2[14] != r_tog_seen;
    assign w_valid   = 32'(r_set) < PARAM_SETS && 32'(r_param) < PARAM_COUNT;
    assign w_wr_idx  = AW'(32'(r_set) * PARAM_COUNT + 32'(r_param));
    assign w_cp_idx  = AW'(32'(r_set) * PARAM_COUNT + 32'(r_cnt));

    assign io_gpio.gp_status   = GPIO_WIDTH'({r_err, r_state != S_IDLE, r_ack});
    assign io_gpio.params_data = r_active;

    always_ff @(posedge i_clk) begin
        if (!i_resetn) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  w_next = w_pending ? S_WRITE : S_IDLE;
            S_WRITE: w_next = r_commit && w_valid ? S_COPY : S_DONE;
            S_COPY:  w_next = r_cnt == CW'(PARAM_COUNT - 1) ? S_DONE : S_COPY;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_resetn) begin
            r_in_s1    <= '0;
            r_in_s2    <= '0;
            r_ctrl_s1  <= '0;
            r_ctrl_s2  <= '0;
            r_tog_seen <= 1'b0;
            r_ack      <= 1'b0;
            r_err      <= 1'b0;
            r_clr      <= 1'b0;
            r_commit   <= 1'b0;
            r_set      <= '0;
            r_param    <= '0;
            r_data     <= '0;
            r_cnt      <= '0;
            r_active   <= '0;
            for (int i = 0; i < NW; i++) r_shadow[i] <= '0;
        end else begin
            r_in_s1   <= io_gpio.gp_in;
            r_in_s2   <= r_in_s1;
            r_ctrl_s1 <= {io_gpio.gp_ctrl[15:13], io_gpio.gp_ctrl[11:0]};
            r_ctrl_s2 <= r_ctrl_s1;
            case (r_state)
                S_IDLE: if (w_pending) begin
                    r_data     <= r_in_s2;
                    r_set      <= r_ctrl_s2[3:0];
                    r_param    <= r_ctrl_s2[11:4];
                    r_clr      <= r_ctrl_s2[12];
                    r_commit   <= r_ctrl_s2[13];
                    r_tog_seen <= r_ctrl_s2[14];
                end
                S_WRITE: begin
                    if (w_valid) r_shadow[w_wr_idx] <= r_data;
                    r_err <= !w_valid || (r_err && !r_clr);
                    r_cnt <= '0;
                end
                S_COPY: begin
                    r_active[w_cp_idx*GPIO_WIDTH +: GPIO_WIDTH] <= r_shadow[w_cp_idx];
                    r_cnt <= r_cnt + 1'b1;
                end
                default: r_ack <= r_tog_seen;
            endcase
        end
    end
endmodule

// File: tb/tb_gpio_params_loader.sv
// tb_gpio_params_loader: directed checks of the GPIO parameter loader handshake, shadow/active banks and errors.
module tb_gpio_params_loader;
    localparam int W = 32, PC = 16, PS = 16;

    logic clk = 1'b0;
    logic rstn;
    logic tog;
    int   checks = 0;
    int   errors = 0;
    int   n;
    logic [PS*PC*W-1:0] exp_pd;

    gpio_params_loader_if #(.GPIO_WIDTH(W), .PARAM_COUNT(PC), .PARAM_SETS(PS)) gpio ();

    gpio_params_loader #(.GPIO_WIDTH(W), .PARAM_COUNT(PC), .PARAM_SETS(PS)) dut (
        .i_clk    (clk),
        .i_resetn (rstn),
        .io_gpio  (gpio)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pd(input string tag);
        int k;
        checks++;
        assert (gpio.params_data === exp_pd) else begin
            errors++;
            k = 0;
            while (k < PS*PC - 1 && gpio.params_data[k*W +: W] === exp_pd[k*W +: W]) k++;
            $error("FAIL %s word %0d observed=%h expected=%h", tag, k, gpio.params_data[k*W +: W], exp_pd[k*W +: W]);
        end
    endtask

    task automatic set_word(input int s, input int p, input logic [31:0] v);
        exp_pd[(s*PC+p)*W +: W] = v;
    endtask

    task automatic send(input logic [31:0] d, input logic [3:0] s, input logic [7:0] p, input logic clr, input logic cm);
        gpio.gp_in   = d;
        gpio.gp_ctrl = {tog, cm, clr, 1'b0, p, s};
        tick();
        tick();
        tog = ~tog;
        gpio.gp_ctrl[15] = tog;
    endtask

    task automatic wait_ack(input logic v, input int max, output int cnt);
        cnt = 0;
        do begin
            tick();
            cnt++;
        end while (gpio.gp_status[0] !== v && cnt < max);
        chk("ack_wait", {31'b0, gpio.gp_status[0]}, {31'b0, v});
    endtask

    initial begin
        exp_pd = '0;
        tog = 1'b0;
        rstn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            gpio.gp_in   = $urandom;
            gpio.gp_ctrl = 16'($urandom);
            tick();
            chk_pd("reset_pd");
            chk("reset_status", gpio.gp_status, 32'h0);
        end
        gpio.gp_in   = '0;
        gpio.gp_ctrl = '0;
        rstn = 1'b1;
        tick();
        chk_pd("post_reset_pd");
        chk("post_reset_status", gpio.gp_status, 32'h0);

        // single write, no commit: BUSY after edges 3 and 4, ACK at edge 5
        send(32'hDEADBEEF, 4'd2, 8'd5, 1'b0, 1'b0);
        tick(); chk("w1_e1", gpio.gp_status, 32'h0);
        tick(); chk("w1_e2", gpio.gp_status, 32'h0);
        tick(); chk("w1_e3", gpio.gp_status, 32'h2);
        tick(); chk("w1_e4", gpio.gp_status, 32'h2);
        tick(); chk("w1_e5", gpio.gp_status, 32'h1);
        chk_pd("w1_pd");

        for (int p = 0; p < 15; p++) begin
            send(32'h11111111 + 32'(p), 4'd3, 8'(p), 1'b0, 1'b0);
            wait_ack(tog, 20, n);
            chk("fill_latency", 32'(n), 32'd5);
        end
        chk_pd("fill_pd");
        send(32'hCAFEF00D, 4'd3, 8'd15, 1'b0, 1'b1);
        for (int e = 1; e <= 4; e++) tick();
        chk_pd("commit_e4_pd");
        for (int p = 0; p < 16; p++) begin
            tick();
            set_word(3, p, p == 15 ? 32'hCAFEF00D : 32'h11111111 + 32'(p));
            chk_pd($sformatf("commit_e%0d_pd", 5 + p));
        end
        chk("commit_e20_status", gpio.gp_status, {30'b0, 1'b1, ~tog});
        tick();
        chk("commit_e21_status", gpio.gp_status, {31'b0, tog});

        // out-of-range param 16 must not alias onto set 1 word 0
        send(32'h55555555, 4'd0, 8'd16, 1'b0, 1'b1);
        wait_ack(tog, 30, n);
        chk("oor_latency", 32'(n), 32'd5);
        chk("oor_status", gpio.gp_status, {29'b0, 1'b1, 1'b0, tog});
        chk_pd("oor_pd");
        send(32'h55555555, 4'd0, 8'd200, 1'b1, 1'b0);
        wait_ack(tog, 30, n);
        chk("oor_clr_status", gpio.gp_status, {29'b0, 1'b1, 1'b0, tog});
        send(32'h12345678, 4'd0, 8'd0, 1'b1, 1'b0);
        wait_ack(tog, 30, n);
        chk("clr_status", gpio.gp_status, {31'b0, tog});
        send(32'hA5A5A5A5, 4'd1, 8'd1, 1'b0, 1'b1);
        wait_ack(tog, 30, n);
        chk("set1_latency", 32'(n), 32'd21);
        set_word(1, 1, 32'hA5A5A5A5);
        chk_pd("set1_pd");

        // second request raised mid-COPY waits for the first to finish
        send(32'h44440000, 4'd4, 8'd0, 1'b0, 1'b1);
        for (int e = 0; e < 8; e++) tick();
        gpio.gp_in   = 32'h44440001;
        gpio.gp_ctrl = {tog, 1'b1, 1'b0, 1'b0, 8'd1, 4'd4};
        tick();
        tog = ~tog;
        gpio.gp_ctrl[15] = tog;
        wait_ack(~tog, 40, n);
        set_word(4, 0, 32'h44440000);
        chk_pd("busy_first_pd");
        wait_ack(tog, 40, n);
        chk("busy_second_latency", 32'(n), 32'd19);
        set_word(4, 1, 32'h44440001);
        chk_pd("busy_second_pd");
        chk("busy_status", gpio.gp_status, {31'b0, tog});

        // reset while cnt=7 in COPY
        send(32'h77777777, 4'd5, 8'd0, 1'b0, 1'b1);
        for (int e = 0; e < 11; e++) tick();
        set_word(5, 0, 32'h77777777);
        chk_pd("midcopy_pd");
        chk("midcopy_busy", {31'b0, gpio.gp_status[1]}, 32'h1);
        rstn = 1'b0;
        gpio.gp_in   = '0;
        gpio.gp_ctrl = '0;
        tog = 1'b0;
        tick();
        exp_pd = '0;
        chk_pd("rst_copy_pd");
        chk("rst_copy_status", gpio.gp_status, 32'h0);
        rstn = 1'b1;
        tick();
        chk("rst_release_status", gpio.gp_status, 32'h0);
        send(32'h66666666, 4'd6, 8'd3, 1'b0, 1'b1);
        wait_ack(tog, 40, n);
        chk("after_rst_latency", 32'(n), 32'd21);
        set_word(6, 3, 32'h66666666);
        chk_pd("after_rst_pd");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
